idecode: RTL and testbench

Decode stage of the rvga pipeline: registers the fetched control word from instruction fetch, decodes the RV32I instruction, generates the immediate, and reads the 32-entry integer register file. It also owns the register file write port driven by writeback and produces the load-use hazard signal that stalls fetch. Output is the decoded control word handed to execute.

---
 rtl/idecode_if.sv | 44 ++++
 rtl/idecode.sv | 150 +++++++++++++++
 tb/tb_idecode.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/idecode_if.sv
// Control-word type shared by the rvga pipeline and the decode-stage port bundle.
// The decode side takes the slave modport; the driving environment takes master.
package rvga_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        rf_we;
    logic        illegal;
    logic [31:0] rd_data;
  } rvga_cword;
endpackage

interface idecode_if;
  import rvga_pkg::*;

  logic       stall;
  logic       flush;
  rvga_cword  if_de_cword;
  rvga_cword  wb_de_cword;
  logic       ex_load;
  logic [4:0] ex_rd;
  rvga_cword  de_ex_cword;
  logic       de_hazard;

  modport slave (
    input  stall, flush, if_de_cword, wb_de_cword, ex_load, ex_rd,
    output de_ex_cword, de_hazard
  );

  modport master (
    output stall, flush, if_de_cword, wb_de_cword, ex_load, ex_rd,
    input  de_ex_cword, de_hazard
  );
endinterface

// File: rtl/idecode.sv
// RV32I decode stage: field/immediate decode, register file read with writeback bypass.
// One-cycle latency; stall holds the output, load-use hazard inserts a bubble.
module idecode
  import rvga_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic      clk,
  input  logic      rst,
  idecode_if.slave  bus
);

  localparam int XLEN = 8 * BYTES_PER_WORD;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] r_rf [NUM_REGS];
  rvga_cword       r_out;

  logic [31:0]     w_inst;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_wr_class;
  logic            w_illegal;
  logic [31:0]     w_imm;
  logic            w_wb_we;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  rvga_cword       w_dec;
  logic            w_unused;

  assign w_inst = bus.if_de_cword.inst;
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];
  assign w_rd   = w_inst[11:7];

  // Fields of the shared word that this stage never consumes.
  assign w_unused = ^{bus.if_de_cword, bus.wb_de_cword};

  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_wr_class = 1'b0;
    w_illegal  = 1'b0;
    w_imm      = '0;
    case (w_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_wr_class = 1'b1;
        w_imm      = {w_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_wr_class = 1'b1;
        w_imm      = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                      w_inst[20], w_inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_wr_class = 1'b1;
        w_rs1_used = 1'b1;
        w_imm      = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OPC_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                      w_inst[30:25], w_inst[11:8], 1'b0};
      end
      OPC_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      OPC_OP: begin
        w_wr_class = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wb_we = bus.wb_de_cword.valid & bus.wb_de_cword.rf_we &
                   (bus.wb_de_cword.rd != 5'd0);

  // Writeback lands at the same edge this read is registered, so forward it.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != 5'd0)
      w_rs1_val = (w_wb_we && bus.wb_de_cword.rd == w_rs1) ? bus.wb_de_cword.rd_data
                                                          : r_rf[w_rs1];
    if (w_rs2 != 5'd0)
      w_rs2_val = (w_wb_we && bus.wb_de_cword.rd == w_rs2) ? bus.wb_de_cword.rd_data
                                                          : r_rf[w_rs2];
  end

  always_comb begin
    w_dec          = '0;
    w_dec.valid    = bus.if_de_cword.valid;
    w_dec.pc       = bus.if_de_cword.pc;
    w_dec.inst     = w_inst;
    w_dec.opcode   = w_inst[6:0];
    w_dec.funct3   = w_inst[14:12];
    w_dec.funct7   = w_inst[31:25];
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.rd       = w_rd;
    w_dec.rs1_data = w_rs1_used ? w_rs1_val : '0;
    w_dec.rs2_data = w_rs2_used ? w_rs2_val : '0;
    w_dec.imm      = w_imm;
    w_dec.rf_we    = w_wr_class & (w_rd != 5'd0);
    w_dec.illegal  = w_illegal;
  end

  assign w_hazard = ~rst & bus.if_de_cword.valid & bus.ex_load & (bus.ex_rd != 5'd0) &
                    ((w_rs1_used & (w_rs1 == bus.ex_rd)) |
                     (w_rs2_used & (w_rs2 == bus.ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[bus.wb_de_cword.rd] <= bus.wb_de_cword.rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_out <= '0;
    end else if (!bus.stall) begin
      r_out <= w_hazard ? '0 : w_dec;
    end
  end

  assign bus.de_ex_cword = r_out;
  assign bus.de_hazard   = w_hazard;

endmodule

// File: tb/tb_idecode.sv
// Directed-vector bench for the decode stage: decode, immediates, bypass, hazard, stall/flush.
module tb_idecode;
  import rvga_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  idecode_if bus ();

  idecode #(.NUM_REGS(32), .BYTES_PER_WORD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.if_de_cword       = '0;
    bus.if_de_cword.valid = v;
    bus.if_de_cword.pc    = pc;
    bus.if_de_cword.inst  = inst;
  endtask

  task automatic wback(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_de_cword         = '0;
    bus.wb_de_cword.valid   = v;
    bus.wb_de_cword.rf_we   = v;
    bus.wb_de_cword.rd      = rd;
    bus.wb_de_cword.rd_data = data;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.ex_load = 1'b0;
    bus.ex_rd = 5'd0;
    fetch(1'b0, 32'h0, 32'h0);
    wback(1'b0, 5'd0, 32'h0);
    edge_sample();

    // x7 written before a second reset must come back cleared.
    @(negedge clk);
    rst = 1'b0;
    wback(1'b1, 5'd7, 32'h0000_0077);
    edge_sample();

    @(negedge clk);
    rst = 1'b1;
    wback(1'b1, 5'd5, 32'h0000_AAAA);
    bus.ex_load = 1'b1;
    bus.ex_rd = 5'd3;
    fetch(1'b1, 32'h80, 32'h0021_8233);
    #1 chk("rst_hazard", {31'b0, bus.de_hazard}, 32'd0);
    edge_sample();
    chk("rst_valid", {31'b0, bus.de_ex_cword.valid}, 32'd0);
    chk("rst_pc", bus.de_ex_cword.pc, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    bus.ex_load = 1'b0;
    bus.ex_rd = 5'd0;
    wback(1'b0, 5'd0, 32'h0);
    fetch(1'b1, 32'h100, 32'h0053_8433);   // ADD x8,x7,x5
    edge_sample();
    chk("post_rst_valid", {31'b0, bus.de_ex_cword.valid}, 32'd1);
    chk("post_rst_pc", bus.de_ex_cword.pc, 32'h100);
    chk("x7_cleared", bus.de_ex_cword.rs1_data, 32'h0);
    chk("x5_dropped", bus.de_ex_cword.rs2_data, 32'h0);

    @(negedge clk);
    fetch(1'b1, 32'h104, 32'hFFB0_0093);   // ADDI x1,x0,-5
    edge_sample();
    chk("addi_opcode", {25'b0, bus.de_ex_cword.opcode}, 32'h13);
    chk("addi_rd", {27'b0, bus.de_ex_cword.rd}, 32'd1);
    chk("addi_imm", bus.de_ex_cword.imm, 32'hFFFF_FFFB);
    chk("addi_rf_we", {31'b0, bus.de_ex_cword.rf_we}, 32'd1);
    chk("addi_rs1_data", bus.de_ex_cword.rs1_data, 32'h0);

    @(negedge clk);
    fetch(1'b1, 32'h108, 32'hFE00_0CE3);   // BEQ x0,x0,-8
    edge_sample();
    chk("beq_imm", bus.de_ex_cword.imm, 32'hFFFF_FFF8);
    chk("beq_rf_we", {31'b0, bus.de_ex_cword.rf_we}, 32'd0);
    chk("beq_illegal", {31'b0, bus.de_ex_cword.illegal}, 32'd0);

    @(negedge clk);
    fetch(1'b1, 32'h10C, 32'h0000_006F);   // JAL x0,0
    edge_sample();
    chk("jal_x0_rf_we", {31'b0, bus.de_ex_cword.rf_we}, 32'd0);
    chk("jal_illegal", {31'b0, bus.de_ex_cword.illegal}, 32'd0);

    @(negedge clk);
    fetch(1'b1, 32'h110, 32'h0000_007F);
    edge_sample();
    chk("bad_illegal", {31'b0, bus.de_ex_cword.illegal}, 32'd1);
    chk("bad_rf_we", {31'b0, bus.de_ex_cword.rf_we}, 32'd0);
    chk("bad_imm", bus.de_ex_cword.imm, 32'h0);

    @(negedge clk);
    wback(1'b1, 5'd3, 32'hDEAD_BEEF);
    fetch(1'b1, 32'h114, 32'h0031_8233);   // ADD x4,x3,x3
    edge_sample();
    chk("byp_rs1", bus.de_ex_cword.rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2", bus.de_ex_cword.rs2_data, 32'hDEAD_BEEF);
    chk("add_rd", {27'b0, bus.de_ex_cword.rd}, 32'd4);

    @(negedge clk);
    wback(1'b0, 5'd0, 32'h0);
    edge_sample();
    chk("arr_rs1", bus.de_ex_cword.rs1_data, 32'hDEAD_BEEF);

    @(negedge clk);
    wback(1'b1, 5'd0, 32'h0000_1234);
    fetch(1'b1, 32'h118, 32'h0000_02B3);   // ADD x5,x0,x0
    edge_sample();
    chk("x0_byp", bus.de_ex_cword.rs1_data, 32'h0);

    @(negedge clk);
    wback(1'b0, 5'd0, 32'h0);
    fetch(1'b1, 32'h11C, 32'h0001_81B7);   // LUI x3,0x18 (rs1 field = 3)
    edge_sample();
    chk("lui_imm", bus.de_ex_cword.imm, 32'h0001_8000);
    chk("lui_rs1_unused", bus.de_ex_cword.rs1_data, 32'h0);
    chk("lui_rf_we", {31'b0, bus.de_ex_cword.rf_we}, 32'd1);

    // Load-use hazard on rs1 then rs2.
    @(negedge clk);
    bus.ex_load = 1'b1;
    bus.ex_rd = 5'd3;
    fetch(1'b1, 32'h120, 32'h0021_8233);   // ADD x4,x3,x2
    #1 chk("haz_rs1", {31'b0, bus.de_hazard}, 32'd1);
    edge_sample();
    chk("haz_bubble", {31'b0, bus.de_ex_cword.valid}, 32'd0);

    @(negedge clk);
    bus.ex_rd = 5'd2;
    #1 chk("haz_rs2", {31'b0, bus.de_hazard}, 32'd1);

    @(negedge clk);
    bus.ex_rd = 5'd0;
    #1 chk("haz_rd0", {31'b0, bus.de_hazard}, 32'd0);
    edge_sample();
    chk("haz_clear_valid", {31'b0, bus.de_ex_cword.valid}, 32'd1);
    chk("haz_clear_inst", bus.de_ex_cword.inst, 32'h0021_8233);

    @(negedge clk);
    bus.ex_rd = 5'd3;
    fetch(1'b1, 32'h124, 32'h0001_81B7);
    #1 chk("haz_lui", {31'b0, bus.de_hazard}, 32'd0);

    @(negedge clk);
    bus.ex_load = 1'b0;
    fetch(1'b1, 32'h128, 32'h0021_8233);
    #1 chk("haz_noload", {31'b0, bus.de_hazard}, 32'd0);

    @(negedge clk);
    bus.ex_load = 1'b1;
    fetch(1'b0, 32'h128, 32'h0021_8233);
    #1 chk("haz_invalid", {31'b0, bus.de_hazard}, 32'd0);

    @(negedge clk);
    bus.ex_load = 1'b0;
    bus.ex_rd = 5'd0;
    fetch(1'b1, 32'h200, 32'hFFB0_0093);
    edge_sample();
    chk("pre_stall_pc", bus.de_ex_cword.pc, 32'h200);

    // Output holds while stalled; the register file still accepts writeback.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.stall = 1'b1;
      fetch(1'b1, 32'h300 + 32'(i), 32'h0021_8233);
      wback(i == 0, 5'd9, 32'h0000_0099);
      edge_sample();
      chk("stall_pc", bus.de_ex_cword.pc, 32'h200);
      chk("stall_inst", bus.de_ex_cword.inst, 32'hFFB0_0093);
    end

    @(negedge clk);
    bus.stall = 1'b0;
    wback(1'b0, 5'd0, 32'h0);
    fetch(1'b1, 32'h304, 32'h0004_8533);   // ADD x10,x9,x0
    edge_sample();
    chk("stall_wr_x9", bus.de_ex_cword.rs1_data, 32'h0000_0099);

    @(negedge clk);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    fetch(1'b1, 32'h308, 32'hFFB0_0093);
    edge_sample();
    chk("flush_stall_valid", {31'b0, bus.de_ex_cword.valid}, 32'd0);
    chk("flush_stall_pc", bus.de_ex_cword.pc, 32'h0);

    @(negedge clk);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    fetch(1'b1, 32'h30C, 32'hFFB0_0093);
    edge_sample();
    chk("recover_valid", {31'b0, bus.de_ex_cword.valid}, 32'd1);
    chk("recover_pc", bus.de_ex_cword.pc, 32'h30C);

    @(negedge clk);
    bus.flush = 1'b1;
    edge_sample();
    chk("flush_valid", {31'b0, bus.de_ex_cword.valid}, 32'd0);

    @(negedge clk);
    bus.flush = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
